// File: rtl/mxu_sequencer_pkg.sv
// Shared definitions for the MXU job sequencer: precision width, FSM states
// and the skew + core + de-skew pipeline length.
package mxu_sequencer_pkg;

    localparam int unsigned LOG_ALLOWED_PRECISIONS = 2;

    typedef logic [LOG_ALLOWED_PRECISIONS-1:0] precision_t;

    typedef enum logic [1:0] {
        SEQ_IDLE   = 2'd0,
        SEQ_STREAM = 2'd1,
        SEQ_DRAIN  = 2'd2,
        SEQ_DONE   = 2'd3
    } seq_state_e;

    // Enabled cycles from the first skew stage to the de-skewed output.
    function automatic int unsigned seq_pipe_len(input int unsigned m,
                                                 input int unsigned k,
                                                 input int unsigned core_latency);
        return (k - 1) + core_latency + (m - 1);
    endfunction

endpackage

// File: rtl/mxu_sequencer_if.sv
// Valid/ready vector streams between the DMA side and the MXU sequencer.
interface mxu_sequencer_if;

    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );

    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

endinterface

// File: rtl/mxu_valid_tracker.sv
// Gated valid shift register mirroring the wrapper pipeline; vout is the
// valid flag for the vector currently on the wrapper output.
module mxu_valid_tracker #(
    parameter int unsigned L = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic shift,
    input  logic vin,
    output logic vout
);

    logic [L-1:0] pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            pipe <= '0;
        end else if (shift) begin
            pipe <= (pipe << 1) | L'(vin);
        end
    end

    assign vout = pipe[L-1];

endmodule

// File: rtl/mxu_sequencer.sv
// Weight-stationary MXU job controller: streams N vectors in, collects N out.
// Optional MXU_SEQ_PERF_CNT_EN adds stall_cycles / busy_cycles counters.
module mxu_sequencer
    import mxu_sequencer_pkg::*;
#(
    parameter int unsigned M            = 3,
    parameter int unsigned K            = 3,
    parameter int unsigned CORE_LATENCY = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] n_vectors,
    input  precision_t       cfg_data_type,
    input  logic             scan_mode,
    mxu_sequencer_if.slave   dma,
    output logic             mxu_enable,
    output logic             mxu_enable_in_ff,
    output logic             mxu_enable_out_ff,
    output precision_t       mxu_data_type,
    output logic             mxu_test_mode,
    output logic             busy,
    output logic             done
`ifdef MXU_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]      stall_cycles,
    output logic [31:0]      busy_cycles
`endif
);

    localparam int unsigned L = seq_pipe_len(M, K, CORE_LATENCY);

    seq_state_e       state;
    logic [CNT_W-1:0] n_lat;
    logic [CNT_W-1:0] accepted;
    logic [CNT_W-1:0] emitted;

    logic out_valid;
    logic stall;
    logic accept;
    logic emit;
    logic last_emit;
    logic advance;
    logic pipe_reset;

    // The final result needs no further advance: freezing keeps it on y while
    // the sink takes it, and the tracker is cleared so out_valid drops after.
    always_comb begin
        stall      = out_valid && !dma.out_ready;
        emit       = out_valid && dma.out_ready;
        accept     = (state == SEQ_STREAM) && dma.in_valid && !stall;
        last_emit  = (state == SEQ_DRAIN) && emit && (emitted == n_lat - CNT_W'(1));
        advance    = 1'b0;
        if (state == SEQ_STREAM) begin
            advance = dma.in_valid && !stall;
        end else if (state == SEQ_DRAIN) begin
            advance = !stall && !last_emit;
        end
        pipe_reset = reset || last_emit;
    end

    assign dma.in_ready      = (state == SEQ_STREAM) && !stall;
    assign dma.out_valid     = out_valid;
    assign mxu_enable        = advance;
    assign mxu_enable_in_ff  = advance;
    assign mxu_enable_out_ff = advance;

    mxu_valid_tracker #(
        .L(L)
    ) u_valid_tracker (
        .clk  (clk),
        .reset(pipe_reset),
        .shift(advance),
        .vin  (accept),
        .vout (out_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SEQ_IDLE;
            n_lat         <= '0;
            accepted      <= '0;
            emitted       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mxu_data_type <= '0;
            mxu_test_mode <= 1'b0;
        end else begin
            mxu_test_mode <= scan_mode;
            done          <= 1'b0;
            case (state)
                SEQ_IDLE: begin
                    if (start) begin
                        mxu_data_type <= cfg_data_type;
                        n_lat         <= n_vectors;
                        accepted      <= '0;
                        emitted       <= '0;
                        if (n_vectors == '0) begin
                            state <= SEQ_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= SEQ_STREAM;
                            busy  <= 1'b1;
                        end
                    end
                end
                SEQ_STREAM: begin
                    if (emit) begin
                        emitted <= emitted + CNT_W'(1);
                    end
                    if (accept) begin
                        accepted <= accepted + CNT_W'(1);
                        if (accepted == n_lat - CNT_W'(1)) begin
                            state <= SEQ_DRAIN;
                        end
                    end
                end
                SEQ_DRAIN: begin
                    if (emit) begin
                        emitted <= emitted + CNT_W'(1);
                    end
                    if (last_emit) begin
                        state <= SEQ_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                SEQ_DONE: begin
                    state <= SEQ_IDLE;
                end
                default: begin
                    state <= SEQ_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef MXU_SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset || (state == SEQ_IDLE && start)) begin
            stall_cycles <= '0;
            busy_cycles  <= '0;
        end else if (busy) begin
            if (busy_cycles != '1) begin
                busy_cycles <= busy_cycles + 32'd1;
            end
            if (!advance && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
        end
    end
`endif

endmodule
